// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter.
// Drives the shared PS/2 clock/data lines open-drain. It runs the
// inhibit / request-to-send sequence, then shifts out the start bit,
// 8 data bits (LSB first), odd parity and stop on device clock falling
// edges. It then checks the device acknowledge.
//
// Ports:
//   clock, reset  system clock, asynchronous active-low reset
//   ce            sample/step strobe; all state advances only when ce = 1
//   ps2[1:0]      raw line levels: [0] = PS/2 clock, [1] = PS/2 data
//   clk_oe        1 = pull the PS/2 clock line low
//   dat_oe        1 = pull the PS/2 data line low
//   data[7:0]     byte to send, captured on accept
//   start         transfer request, accepted when ce & start & !busy
//   busy          transfer in progress
//   done          one-clock pulse: device acknowledged the byte
//   error         one-clock pulse: transfer aborted (timeout / missing ACK)
//
// Optional feature macro: PS2_TX_RETRY_EN. When it is defined, a failed
// attempt restarts from inhibit up to two more times before error is
// reported.

module ps2_host_tx #(
  parameter int unsigned INHIBIT = 400,
  parameter int unsigned TIMEOUT = 8000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] ps2,
  output logic       clk_oe,
  output logic       dat_oe,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CNT_MAX = (INHIBIT > TIMEOUT) ? INHIBIT : TIMEOUT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LOAD = CW'(INHIBIT);
  localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT);
`ifdef PS2_TX_RETRY_EN
  localparam int unsigned RETRIES = 2;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SHIFT,
    S_ACK,
    S_WAIT
  } state_t;

  // Clock line filter: 7 stored samples plus the live one form an
  // 8-sample window, so a clean fall is reported on the 8th ce tick.
  logic [6:0] filt_hist;
  logic       filt_clk;
  logic       dat_q;
  logic [7:0] window_c;
  logic       fall_c;

  assign window_c = {filt_hist, ps2[0]};
  assign fall_c   = ce && filt_clk && (window_c == 8'h00);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt_hist <= '1;
      filt_clk  <= 1'b1;
      dat_q     <= 1'b1;
    end else if (ce) begin
      filt_hist <= window_c[6:0];
      dat_q     <= ps2[1];
      if (&window_c)
        filt_clk <= 1'b1;
      else if (window_c == 8'h00)
        filt_clk <= 1'b0;
    end
  end

  state_t        state,  state_n;
  logic [CW-1:0] cnt,    cnt_n;
  logic [3:0]    idx,    idx_n;
  logic [7:0]    tx_byte, tx_byte_n;
  logic          clk_oe_n, dat_oe_n, busy_n, done_n, error_n;
  logic          fail_c;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]    retry, retry_n;
`endif

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      tx_byte <= '0;
      clk_oe  <= 1'b0;
      dat_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry   <= '0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      tx_byte <= tx_byte_n;
      clk_oe  <= clk_oe_n;
      dat_oe  <= dat_oe_n;
      busy    <= busy_n;
      done    <= done_n;
      error   <= error_n;
`ifdef PS2_TX_RETRY_EN
      retry   <= retry_n;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    tx_byte_n = tx_byte;
    clk_oe_n  = clk_oe;
    dat_oe_n  = dat_oe;
    busy_n    = busy;
    done_n    = 1'b0;
    error_n   = 1'b0;
    fail_c    = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_n   = retry;
`endif

    if (ce) begin
      unique case (state)
        S_IDLE: begin
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
          if (start && !busy) begin
            tx_byte_n = data;
            cnt_n     = INH_LOAD;
            clk_oe_n  = 1'b1;
            busy_n    = 1'b1;
            state_n   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
            retry_n   = '0;
`endif
          end
        end

        S_INHIBIT: begin
          // Last inhibit tick: release clock and present the start bit.
          if (cnt <= CW'(1)) begin
            clk_oe_n = 1'b0;
            dat_oe_n = 1'b1;
            cnt_n    = TO_LOAD;
            idx_n    = '0;
            state_n  = S_SHIFT;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end

        S_SHIFT: begin
          if (fall_c) begin
            if (idx < 4'd8)
              dat_oe_n = ~tx_byte[idx[2:0]];
            else if (idx == 4'd8)
              dat_oe_n = ^tx_byte;          // odd parity bit is ~^tx_byte
            else begin
              dat_oe_n = 1'b0;              // stop bit: release data
              state_n  = S_ACK;
            end
            idx_n = idx + 4'd1;
            cnt_n = TO_LOAD;
          end else if (cnt <= CW'(1)) begin
            fail_c = 1'b1;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end

        S_ACK: begin
          if (fall_c) begin
            if (!dat_q) begin
              cnt_n   = TO_LOAD;
              state_n = S_WAIT;
            end else begin
              fail_c = 1'b1;
            end
          end else if (cnt <= CW'(1)) begin
            fail_c = 1'b1;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end

        S_WAIT: begin
          // Device has let go of both lines: transfer complete.
          if (filt_clk && dat_q) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = S_IDLE;
          end else if (cnt <= CW'(1)) begin
            fail_c = 1'b1;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end

        default: state_n = S_IDLE;
      endcase

      // Failure: either re-arm from inhibit or abort with both lines released.
      if (fail_c) begin
`ifdef PS2_TX_RETRY_EN
        if (retry < 2'(RETRIES)) begin
          retry_n  = retry + 2'd1;
          cnt_n    = INH_LOAD;
          clk_oe_n = 1'b1;
          dat_oe_n = 1'b0;
          state_n  = S_INHIBIT;
        end else
`endif
        begin
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
          busy_n   = 1'b0;
          error_n  = 1'b1;
          state_n  = S_IDLE;
        end
      end
    end
  end

endmodule
